// File: rtl/key_command_decoder.sv
// UART key-byte decoder: WASD into held movement bits that expire on move ticks, and
// action keys into a small valid/ready command FIFO. Optional macro: KEYDEC_REPEAT_FILTER_EN.
module key_command_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [3:0] move_dir,
    output logic       move_tick,
    output logic       overflow,
    input  logic       ovf_clear,
    output logic [7:0] ignored_cnt
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TCW = $clog2(TICK_DIV);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [3:0]     HOLD_LOAD = 4'(HOLD_TICKS);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] hold_dec(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    logic [3:0]     w_dir;
    logic           w_is_cmd;
    logic [1:0]     w_cmd;
    logic           w_unmapped;
    logic           w_key_v;
    logic           w_cmd_v;
    logic           w_filtered;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;

    logic [TCW-1:0] r_tcnt;
    logic           r_tick;
    logic [3:0]     r_hold [4];
    logic [1:0]     r_mem  [FIFO_DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           r_ovf;
    logic [7:0]     r_ign;

    // Byte classification; bit order of w_dir is {up,down,left,right}
    always_comb begin
        w_dir      = 4'b0000;
        w_is_cmd   = 1'b0;
        w_cmd      = 2'b00;
        w_unmapped = 1'b0;
        case (rx_data)
            8'h57, 8'h77: w_dir = 4'b1000;
            8'h53, 8'h73: w_dir = 4'b0100;
            8'h41, 8'h61: w_dir = 4'b0010;
            8'h44, 8'h64: w_dir = 4'b0001;
            8'h20, 8'h0D: begin w_is_cmd = 1'b1; w_cmd = 2'b00; end
            8'h4A, 8'h6A: begin w_is_cmd = 1'b1; w_cmd = 2'b01; end
            8'h4B, 8'h6B: begin w_is_cmd = 1'b1; w_cmd = 2'b10; end
            8'h58, 8'h78: begin w_is_cmd = 1'b1; w_cmd = 2'b11; end
            default:      w_unmapped = 1'b1;
        endcase
    end

    assign w_key_v = rx_valid && (w_dir != 4'b0000);
    assign w_cmd_v = rx_valid && w_is_cmd;

`ifdef KEYDEC_REPEAT_FILTER_EN
    logic       r_last_v;
    logic [1:0] r_last_code;

    assign w_filtered = r_last_v && (r_last_code == w_cmd);

    // Memory of the last accepted command; forgotten at every move tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_v    <= 1'b0;
            r_last_code <= 2'b00;
        end else if (w_cmd_v && !w_filtered) begin
            r_last_v    <= 1'b1;
            r_last_code <= w_cmd;
        end else if (r_tick) begin
            r_last_v    <= 1'b0;
        end
    end
`else
    assign w_filtered = 1'b0;
`endif

    assign w_push = w_cmd_v && !w_filtered;

    // Free-running tick timebase; pulse is registered one cycle after the last count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tcnt <= (r_tcnt == TICK_LAST) ? '0 : r_tcnt + 1'b1;
            r_tick <= (r_tcnt == TICK_LAST);
        end
    end

    // Hold counters: a load beats a coincident tick; index i^1 is the opposite direction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_hold[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_key_v && w_dir[i])
                    r_hold[i] <= HOLD_LOAD;
                else if (w_key_v && w_dir[i ^ 1])
                    r_hold[i] <= 4'd0;
                else if (r_tick)
                    r_hold[i] <= hold_dec(r_hold[i]);
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && cmd_ready;

    // FIFO: a push into a full queue only succeeds when the head leaves the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 2'b00;
        end else begin
            if (w_push && (!w_full || w_pop)) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_cmd;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_ign <= 8'd0;
        end else begin
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (ovf_clear)
                r_ovf <= 1'b0;
            if (rx_valid && w_unmapped)
                r_ign <= sat_inc8(r_ign);
        end
    end

    assign cmd_valid   = !w_empty;
    assign cmd_code    = r_mem[r_rd_ptr[AW-1:0]];
    assign move_tick   = r_tick;
    assign overflow    = r_ovf;
    assign ignored_cnt = r_ign;
    assign move_dir    = {r_hold[3] != 4'd0, r_hold[2] != 4'd0,
                          r_hold[1] != 4'd0, r_hold[0] != 4'd0};

endmodule

// File: tb/tb_key_command_decoder.sv
// Directed bench for key_command_decoder (TICK_DIV=4, HOLD_TICKS=2, FIFO_DEPTH=4).
module tb_key_command_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] move_dir;
    logic       move_tick;
    logic       overflow;
    logic       ovf_clear = 1'b0;
    logic [7:0] ignored_cnt;

    int vectors = 0;
    int miscompares = 0;

    key_command_decoder #(.FIFO_DEPTH(4), .TICK_DIV(4), .HOLD_TICKS(2)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .move_dir(move_dir), .move_tick(move_tick), .overflow(overflow),
        .ovf_clear(ovf_clear), .ignored_cnt(ignored_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was captured
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Waits (bounded) for move_tick, then steps past the edge that consumes it
    task automatic wait_tick();
        int n = 0;
        while (move_tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tick_seen", 32'(move_tick), 1);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(cmd_valid), 0);
        chk({tag, "_code"}, 32'(cmd_code), 0);
        chk({tag, "_dir"}, 32'(move_dir), 0);
        chk({tag, "_tick"}, 32'(move_tick), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_ign"}, 32'(ignored_cnt), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single 'w' holds for two ticks
        send(8'h77);
        chk("t1_dir_on", 32'(move_dir), 'b1000);
        wait_tick();
        chk("t1_dir_after1", 32'(move_dir), 'b1000);
        wait_tick();
        chk("t1_dir_after2", 32'(move_dir), 'b0000);

        // 2: opposite key replaces, orthogonal keys combine
        send(8'h77);
        chk("t2_up", 32'(move_dir), 'b1000);
        @(negedge clk);
        @(negedge clk);
        send(8'h73);
        chk("t2_down", 32'(move_dir), 'b0100);
        send(8'h61);
        send(8'h57);
        chk("t2_diag", 32'(move_dir), 'b1010);

        // 3: queued commands drain in order
        cmd_ready = 1'b0;
        send(8'h6A);
        chk("t3_valid1", 32'(cmd_valid), 1);
        chk("t3_code1", 32'(cmd_code), 'b01);
        send(8'h6B);
        send(8'h20);
        send(8'h78);
        chk("t3_hold", 32'(cmd_code), 'b01);
        cmd_ready = 1'b1;
        chk("t3_pop0", 32'(cmd_code), 'b01);
        @(negedge clk);
        chk("t3_pop1", 32'(cmd_code), 'b10);
        @(negedge clk);
        chk("t3_pop2", 32'(cmd_code), 'b00);
        @(negedge clk);
        chk("t3_pop3", 32'(cmd_code), 'b11);
        @(negedge clk);
        chk("t3_empty", 32'(cmd_valid), 0);
        cmd_ready = 1'b0;

        // 4: overflow, clear, push+pop while full
        send(8'h4A);
        send(8'h4B);
        send(8'h58);
        send(8'h6A);
        chk("t4_no_ovf_yet", 32'(overflow), 0);
        send(8'h6B);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_head", 32'(cmd_code), 'b01);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 0);
        cmd_ready = 1'b1;
        rx_data   = 8'h78;
        rx_valid  = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        chk("t4_pp_ovf", 32'(overflow), 0);
        chk("t4_pp_head", 32'(cmd_code), 'b10);
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("t4_d1", 32'(cmd_code), 'b11);
        @(negedge clk);
        chk("t4_d2", 32'(cmd_code), 'b01);
        @(negedge clk);
        chk("t4_d3", 32'(cmd_code), 'b11);
        chk("t4_d3_valid", 32'(cmd_valid), 1);
        @(negedge clk);
        chk("t4_empty", 32'(cmd_valid), 0);
        cmd_ready = 1'b0;

        // 5: unmapped bytes saturate the counter and nothing else
        send(8'h31);
        chk("t5_ign1", 32'(ignored_cnt), 1);
        send(8'h7A);
        chk("t5_ign2", 32'(ignored_cnt), 2);
        for (int i = 0; i < 252; i++) send(8'h00);
        chk("t5_ign254", 32'(ignored_cnt), 254);
        for (int i = 0; i < 4; i++) send(8'h00);
        chk("t5_ign_sat", 32'(ignored_cnt), 255);
        chk("t5_fifo", 32'(cmd_valid), 0);
        chk("t5_dir", 32'(move_dir), 0);

        // 6: asynchronous reset mid-operation
        send(8'h6A);
        send(8'h6B);
        send(8'h78);
        send(8'h64);
        chk("t6_dir", 32'(move_dir), 'b0001);
        chk("t6_valid", 32'(cmd_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_tick_c1", 32'(move_tick), 0);
        @(negedge clk);
        chk("t6_tick_c2", 32'(move_tick), 0);
        @(negedge clk);
        chk("t6_tick_c3", 32'(move_tick), 0);
        @(negedge clk);
        chk("t6_tick_c4", 32'(move_tick), 1);
        chk("t6_fifo_lost", 32'(cmd_valid), 0);

        // Repeated command between ticks
        wait_tick();
        send(8'h6A);
        send(8'h6A);
        chk("rep_valid", 32'(cmd_valid), 1);
        chk("rep_code", 32'(cmd_code), 'b01);
        chk("rep_ign", 32'(ignored_cnt), 0);
        cmd_ready = 1'b1;
        @(negedge clk);
`ifdef KEYDEC_REPEAT_FILTER_EN
        chk("rep_single", 32'(cmd_valid), 0);
`else
        chk("rep_second_valid", 32'(cmd_valid), 1);
        chk("rep_second_code", 32'(cmd_code), 'b01);
        @(negedge clk);
        chk("rep_drained", 32'(cmd_valid), 0);
`endif
        cmd_ready = 1'b0;
        chk("rep_ovf", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
